// File: rtl/fpu_norm_pkg.sv
// Shared types and sizing helpers for the FPU normalisation-shift unit.
package fpu_norm_pkg;

  // Widest mantissa (excluding carry) the result record can carry.
  localparam int MAX_MANT_W  = 63;
  localparam int RES_MANT_W  = MAX_MANT_W + 1;
  localparam int MAX_SHIFT_W = 8;

  function automatic int calc_shift_w(input int mant_w);
    return $clog2(mant_w + 1);
  endfunction

  function automatic int num_chunks(input int mant_w, input int chunk_w);
    return (mant_w + chunk_w - 1) / chunk_w;
  endfunction

  // Normalisation result, sized for the widest supported mantissa; narrower
  // instances use the low bits of each field.
  typedef struct packed {
    logic [MAX_SHIFT_W-1:0] shift;
    logic                   right;
    logic [MAX_MANT_W:0]    mant;
    logic                   sticky;
    logic                   zero;
    logic                   clamped;
  } norm_res_t;

endpackage

// File: rtl/fpu_norm_shift_pipe_lzc_chunk.sv
// Leading-one detector for one chunk: found flag plus zeros above the one.
module lzc_chunk #(
  parameter int W     = 8,
  parameter int POS_W = 3
) (
  input  logic [W-1:0]     bits,
  output logic             found,
  output logic [POS_W-1:0] pos
);

  // Scan from the chunk MSB downward; the first set bit wins.
  always_comb begin
    found = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!found && bits[W-1-i]) begin
        found = 1'b1;
        pos   = POS_W'(i);
      end
    end
  end

endmodule

// File: rtl/fpu_norm_shift_pipe.sv
// Two-stage normalisation shifter for the FPU add/sub mantissa path.
module fpu_norm_shift_pipe
  import fpu_norm_pkg::*;
#(
  parameter int MANT_W  = 53,
  parameter int CHUNK_W = 8,
  parameter int SHIFT_W = calc_shift_w(MANT_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MANT_W:0]    in_mant,
  input  logic               in_add,
  input  logic [SHIFT_W-1:0] in_limit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SHIFT_W-1:0] out_shift,
  output logic               out_right,
  output logic [MANT_W:0]    out_mant,
  output logic               out_sticky,
  output logic               out_zero,
  output logic               out_clamped
);

  localparam int NCH   = num_chunks(MANT_W, CHUNK_W);
  localparam int POS_W = $clog2(CHUNK_W);

  logic             s1_advance;
  logic             s1_valid;
  logic [MANT_W:0]  s1_mant;
  logic             s1_add;
  logic [SHIFT_W-1:0] s1_limit;
  logic [NCH-1:0]   s1_found;
  logic [POS_W-1:0] s1_pos [NCH];

  logic [NCH-1:0]   c_found;
  logic [POS_W-1:0] c_pos [NCH];

  logic             s2_valid;
  norm_res_t        res_q;
  norm_res_t        res_d;

  logic [SHIFT_W-1:0] lz;
  logic [SHIFT_W-1:0] shamt;
  logic [MANT_W:0]    sh_mant;
  logic               hit;
  logic               unused_res_hi;

  assign s1_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;

  // Chunks are cut from the MSB side; the last one absorbs any remainder.
  for (genvar k = 0; k < NCH; k++) begin : g_chunk
    localparam int HI     = MANT_W - 1 - k * CHUNK_W;
    localparam int LO_RAW = MANT_W - (k + 1) * CHUNK_W;
    localparam int LO     = (LO_RAW > 0) ? LO_RAW : 0;
    lzc_chunk #(
      .W    (HI - LO + 1),
      .POS_W(POS_W)
    ) u_lzc (
      .bits (in_mant[HI:LO]),
      .found(c_found[k]),
      .pos  (c_pos[k])
    );
  end

  // Stage 1: capture the beat and its per-chunk search results on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_add   <= 1'b0;
      s1_limit <= '0;
      s1_found <= '0;
      for (int unsigned k = 0; k < NCH; k++) s1_pos[k] <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mant  <= in_mant;
        s1_add   <= in_add;
        s1_limit <= in_limit;
        s1_found <= c_found;
        for (int unsigned k = 0; k < NCH; k++) s1_pos[k] <= c_pos[k];
      end
    end
  end

  // Stage 2 datapath: merge chunk results into lz, clamp, and shift.
  always_comb begin
    res_d   = '0;
    hit     = 1'b0;
    lz      = SHIFT_W'(MANT_W);
    shamt   = '0;
    sh_mant = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (!hit && s1_found[k]) begin
        hit = 1'b1;
        lz  = SHIFT_W'(k * CHUNK_W) + SHIFT_W'(s1_pos[k]);
      end
    end
    if (s1_add) begin
      if (s1_mant[MANT_W]) begin
        res_d.right  = 1'b1;
        res_d.shift  = MAX_SHIFT_W'(1);
        res_d.mant   = RES_MANT_W'(s1_mant >> 1);
        res_d.sticky = s1_mant[0];
      end else begin
        res_d.mant = RES_MANT_W'(s1_mant);
        res_d.zero = !hit;
      end
    end else if (!hit) begin
      res_d.zero = 1'b1;
    end else begin
      shamt         = (lz > s1_limit) ? s1_limit : lz;
      sh_mant       = s1_mant << shamt;
      res_d.shift   = MAX_SHIFT_W'(shamt);
      res_d.mant    = RES_MANT_W'(sh_mant);
      res_d.clamped = (lz > s1_limit);
    end
  end

  // Stage 2 register: refill whenever stage 2 is empty or being drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      res_q    <= '0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) res_q <= res_d;
    end
  end

  assign out_valid   = s2_valid;
  assign out_shift   = res_q.shift[SHIFT_W-1:0];
  assign out_right   = res_q.right;
  assign out_mant    = res_q.mant[MANT_W:0];
  assign out_sticky  = res_q.sticky;
  assign out_zero    = res_q.zero;
  assign out_clamped = res_q.clamped;

  // Upper bits of the shared result record are always zero here.
  assign unused_res_hi = ^{res_q.shift[MAX_SHIFT_W-1:SHIFT_W],
                           res_q.mant[MAX_MANT_W:MANT_W+1]};

endmodule

// File: tb/tb_fpu_norm_shift_pipe.sv
// Bench for fpu_norm_shift_pipe: two configurations driven in lockstep.
module tb_fpu_norm_shift_pipe;

  typedef struct packed {
    logic [7:0]  shift;
    logic        right;
    logic [63:0] mant;
    logic        sticky;
    logic        zero;
    logic        clamped;
  } exp_t;

  typedef struct packed {
    int unsigned stamp;
    exp_t        a;
    exp_t        b;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_add = 1'b0;
  logic [53:0] a_in_mant = '0;
  logic [5:0]  a_in_limit = '0;
  logic [24:0] b_in_mant = '0;
  logic [4:0]  b_in_limit = '0;

  logic a_in_ready, a_out_valid, a_out_right, a_out_sticky, a_out_zero, a_out_clamped;
  logic [5:0]  a_out_shift;
  logic [53:0] a_out_mant;
  logic b_in_ready, b_out_valid, b_out_right, b_out_sticky, b_out_zero, b_out_clamped;
  logic [4:0]  b_out_shift;
  logic [24:0] b_out_mant;

  exp_t act_a, act_b;
  item_t q[$];
  int unsigned cyc = 0;
  int nchk = 0;
  int nerr = 0;

  fpu_norm_shift_pipe #(.MANT_W(53), .CHUNK_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_mant(a_in_mant), .in_add(in_add), .in_limit(a_in_limit),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_shift(a_out_shift),
    .out_right(a_out_right), .out_mant(a_out_mant), .out_sticky(a_out_sticky),
    .out_zero(a_out_zero), .out_clamped(a_out_clamped)
  );

  fpu_norm_shift_pipe #(.MANT_W(24), .CHUNK_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_mant(b_in_mant), .in_add(in_add), .in_limit(b_in_limit),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_shift(b_out_shift),
    .out_right(b_out_right), .out_mant(b_out_mant), .out_sticky(b_out_sticky),
    .out_zero(b_out_zero), .out_clamped(b_out_clamped)
  );

  always #5 clk = ~clk;

  // Edge counter used to time-stamp accepted beats.
  always @(posedge clk) cyc <= cyc + 1;

  // Pack DUT outputs into the model's result format.
  always_comb begin
    act_a = '0;
    act_a.shift = 8'(a_out_shift);
    act_a.right = a_out_right;
    act_a.mant = 64'(a_out_mant);
    act_a.sticky = a_out_sticky;
    act_a.zero = a_out_zero;
    act_a.clamped = a_out_clamped;
    act_b = '0;
    act_b.shift = 8'(b_out_shift);
    act_b.right = b_out_right;
    act_b.mant = 64'(b_out_mant);
    act_b.sticky = b_out_sticky;
    act_b.zero = b_out_zero;
    act_b.clamped = b_out_clamped;
  end

  // Reference: normalisation rules in plain arithmetic.
  function automatic exp_t model(input int mw, input logic [63:0] m_in,
                                 input bit add, input int lim);
    exp_t e;
    logic [63:0] full, low, m;
    int lz;
    e = '0;
    full = (64'd1 << (mw + 1)) - 64'd1;
    low = (64'd1 << mw) - 64'd1;
    m = m_in & full;
    if (add) begin
      if (m == 0) e.zero = 1'b1;
      else if (m[mw]) begin
        e.right = 1'b1;
        e.shift = 8'd1;
        e.mant = m >> 1;
        e.sticky = m[0];
      end else e.mant = m;
    end else if ((m & low) == 0) begin
      e.zero = 1'b1;
    end else begin
      lz = 0;
      for (int b = mw - 1; b >= 0; b--) begin
        if (m[b]) begin
          lz = mw - 1 - b;
          break;
        end
      end
      e.shift = 8'((lz > lim) ? lim : lz);
      e.mant = (m << e.shift) & full;
      e.clamped = (lz > lim);
    end
    return e;
  endfunction

  function automatic exp_t mk(input int sh, input bit r, input logic [63:0] m,
                              input bit st, input bit z, input bit cl);
    exp_t e;
    e.shift = 8'(sh);
    e.right = r;
    e.mant = m;
    e.sticky = st;
    e.zero = z;
    e.clamped = cl;
    return e;
  endfunction

  task automatic check1(input string nm, input logic [95:0] act, input logic [95:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every cycle check handshake, validity and head-of-queue data.
  always @(negedge clk) begin
    logic exp_rdy, exp_ov;
    item_t it;
    if (!rst_n) begin
      q.delete();
    end else begin
      exp_rdy = !(q.size() == 2 && !out_ready);
      exp_ov = (q.size() > 0) && (cyc >= q[0].stamp + 1);
      check1("in_ready_A", 96'(a_in_ready), 96'(exp_rdy));
      check1("in_ready_B", 96'(b_in_ready), 96'(exp_rdy));
      check1("out_valid_A", 96'(a_out_valid), 96'(exp_ov));
      check1("out_valid_B", 96'(b_out_valid), 96'(exp_ov));
      if (exp_ov) begin
        check1("result_A", 96'(act_a), 96'(q[0].a));
        check1("result_B", 96'(act_b), 96'(q[0].b));
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && exp_rdy) begin
        it.stamp = cyc + 1;
        it.a = model(53, 64'(a_in_mant), in_add, int'(a_in_limit));
        it.b = model(24, 64'(b_in_mant), in_add, int'(b_in_limit));
        q.push_back(it);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One beat into an empty pipe; check latency and literal results.
  task automatic directed(input string nm, input logic [53:0] ma, input logic [24:0] mb,
                          input bit add, input logic [5:0] la, input logic [4:0] lb,
                          input exp_t ea, input exp_t eb);
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_add = add;
    a_in_mant = ma;
    b_in_mant = mb;
    a_in_limit = la;
    b_in_limit = lb;
    lat = 0;
    do begin
      step();
      in_valid = 1'b0;
      lat++;
    end while (!a_out_valid && lat < 8);
    check1({nm, "_latency"}, 96'(lat), 96'(2));
    check1({nm, "_A"}, 96'(act_a), 96'(ea));
    check1({nm, "_B"}, 96'(act_b), 96'(eb));
    step();
  endtask

  task automatic rand_inputs();
    logic [63:0] r;
    r = {$urandom, $urandom} >> $urandom_range(0, 63);
    if ($urandom_range(0, 9) == 0) r = '0;
    a_in_mant = r[53:0];
    r = {$urandom, $urandom} >> $urandom_range(16, 63);
    if ($urandom_range(0, 9) == 0) r = '0;
    b_in_mant = r[24:0];
    in_add = 1'($urandom_range(0, 1));
    a_in_limit = 6'($urandom_range(0, 63));
    b_in_limit = 5'($urandom_range(0, 31));
  endtask

  initial begin
    repeat (2) step();
    rst_n = 1'b1;
    check1("rst_out_valid_A", 96'(a_out_valid), 96'(0));
    check1("rst_in_ready_A", 96'(a_in_ready), 96'(1));
    check1("rst_data_A", 96'(act_a), 96'(0));
    check1("rst_data_B", 96'(act_b), 96'(0));

    directed("sub_found", 54'd1 << 40, 25'd1 << 11, 1'b0, 6'd63, 5'd31,
             mk(12, 0, 64'd1 << 52, 0, 0, 0), mk(12, 0, 64'd1 << 23, 0, 0, 0));
    directed("sub_clamp", 54'd1 << 40, 25'd1 << 11, 1'b0, 6'd5, 5'd5,
             mk(5, 0, 64'd1 << 45, 0, 0, 1), mk(5, 0, 64'd1 << 16, 0, 0, 1));
    directed("add_carry", (54'd1 << 53) | 54'd1, (25'd1 << 24) | 25'd1, 1'b1, 6'd3, 5'd3,
             mk(1, 1, 64'd1 << 52, 1, 0, 0), mk(1, 1, 64'd1 << 23, 1, 0, 0));
    directed("add_nocarry", 54'h1_2345_6789_ABCD, 25'h0AB_CDEF, 1'b1, 6'd0, 5'd0,
             mk(0, 0, 64'h1_2345_6789_ABCD, 0, 0, 0), mk(0, 0, 64'hAB_CDEF, 0, 0, 0));
    directed("sub_zero", 54'd1 << 53, 25'd1 << 24, 1'b0, 6'd10, 5'd10,
             mk(0, 0, 64'd0, 0, 1, 0), mk(0, 0, 64'd0, 0, 1, 0));
    directed("sub_lim0", 54'd1, 25'd1, 1'b0, 6'd0, 5'd0,
             mk(0, 0, 64'd1, 0, 0, 1), mk(0, 0, 64'd1, 0, 0, 1));

    // Random stream with pseudo-random backpressure.
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    check1("drained", 96'(q.size()), 96'(0));

    // Fill both stages under stall, then reset.
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_inputs();
    step();
    rand_inputs();
    step();
    rand_inputs();
    step();
    check1("full_in_ready_A", 96'(a_in_ready), 96'(0));
    check1("full_out_valid_A", 96'(a_out_valid), 96'(1));
    rst_n = 1'b0;
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    check1("midrst_out_valid_A", 96'(a_out_valid), 96'(0));
    check1("midrst_out_valid_B", 96'(b_out_valid), 96'(0));
    check1("midrst_in_ready_A", 96'(a_in_ready), 96'(1));
    check1("midrst_in_ready_B", 96'(b_in_ready), 96'(1));
    out_ready = 1'b1;
    repeat (6) step();

    // Short random run after reset to confirm normal operation resumes.
    for (int i = 0; i < 60; i++) begin
      rand_inputs();
      in_valid = ($urandom_range(0, 1) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    check1("drained_final", 96'(q.size()), 96'(0));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
